// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared definitions for the memory-mapped countdown timer
//
// Purpose: FSM state encoding, register word offsets, CTRL bit positions and
//          mode constants used by timer_dev and anything that decodes its map.
// Ports:   none (package).
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  localparam logic [1:0] CTRL_OFS   = 2'd0;
  localparam logic [1:0] PRESET_OFS = 2'd1;
  localparam logic [1:0] COUNT_OFS  = 2'd2;
  localparam logic [1:0] STAT_OFS   = 2'd3;

  localparam int EN_BIT   = 0;
  localparam int MODE_LSB = 1;
  localparam int IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with level interrupt
//
// Purpose: one timer window on the processor bridge. Word registers CTRL,
//          PRESET, COUNT (read-only) and a reserved/status word. Read data is
//          combinational from Addr; writes land on the rising clock edge.
//          Optional macro TIMER_STATUS_EN exposes irq_pend at Addr 3 (W1C).
// Ports:
//   clk   in   system clock, rising edge
//   reset in   asynchronous active-low reset
//   Addr  in   [1:0] word offset: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved/status
//   WE    in   word write strobe for this window
//   DIn   in   [31:0] write data
//   DOut  out  [31:0] read data for Addr
//   IRQ   out  level interrupt = CTRL.IM & irq_pend
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic        pend_set;
  logic        pend_clr;
  logic [1:0]  mode;

  assign mode = ctrl_q[MODE_LSB +: 2];

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_set = 1'b0;
    pend_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_q[EN_BIT]) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[EN_BIT]) begin
          state_d = IDLE;
        end else if (count_q <= 32'd1) begin
          // Treating 1 and 0 alike makes a zero preset behave as one and
          // keeps COUNT from ever wrapping below zero.
          count_d  = 32'd0;
          pend_set = 1'b1;
          state_d  = INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      INT: begin
        if (mode == MODE_RELOAD) begin
          pend_clr = 1'b1;
          state_d  = LOAD;
        end else begin
          ctrl_d[EN_BIT] = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // CPU writes are applied after the FSM so a CTRL write overrides the
    // FSM clearing En in the same cycle.
    if (WE) begin
      case (Addr)
        CTRL_OFS: begin
          ctrl_d   = DIn[3:0];
          pend_clr = 1'b1;
        end
        PRESET_OFS: begin
          preset_d = DIn;
          pend_clr = 1'b1;
        end
`ifdef TIMER_STATUS_EN
        STAT_OFS: begin
          if (DIn[0]) pend_clr = 1'b1;
        end
`endif
        default: ;
      endcase
    end

    // Set beats clear so an expiry coinciding with a clearing write is kept.
    if (pend_set)      pend_d = 1'b1;
    else if (pend_clr) pend_d = 1'b0;
    else               pend_d = pend_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= PRESET_RST;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (Addr)
      CTRL_OFS:   DOut = {28'd0, ctrl_q};
      PRESET_OFS: DOut = preset_q;
      COUNT_OFS:  DOut = count_q;
`ifdef TIMER_STATUS_EN
      STAT_OFS:   DOut = {31'd0, pend_q};
`endif
      default:    DOut = 32'd0;
    endcase
  end

  assign IRQ = ctrl_q[IM_BIT] & pend_q;

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - scoreboard bench for timer_dev
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic        WE = 1'b0;
  logic [31:0] DIn = 32'd0;
  logic [31:0] DOut;
  logic        IRQ;

  timer_dev #(.PRESET_RST(32'h0)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE),
    .DIn(DIn), .DOut(DOut), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: timer phases and register contents as plain variables.
  // phase 0 waiting for enable, 1 about to load, 2 counting, 3 just expired.
  int          m_phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  longint      m_count;
  bit          m_pend;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return {28'd0, m_ctrl};
      2'd1: return m_preset;
      2'd2: return m_count[31:0];
`ifdef TIMER_STATUS_EN
      default: return {31'd0, m_pend};
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic logic m_irq();
    return m_ctrl[3] && m_pend;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ctrl = 4'd0; m_preset = 32'h0; m_count = 0; m_pend = 0;
  endtask

  task automatic model_step(input logic we, input logic [1:0] a, input logic [31:0] d);
    int          ph;
    logic [3:0]  c;
    logic [31:0] p;
    longint      cnt;
    bit          expired, cleared;
    ph = m_phase; c = m_ctrl; p = m_preset; cnt = m_count;
    expired = 0; cleared = 0;
    if (m_phase == 0) begin
      if (m_ctrl[0]) ph = 1;
    end else if (m_phase == 1) begin
      cnt = m_preset; ph = 2;
    end else if (m_phase == 2) begin
      if (!m_ctrl[0]) ph = 0;
      else begin
        cnt = (m_count > 0) ? m_count - 1 : 0;
        if (cnt == 0) begin expired = 1; ph = 3; end
      end
    end else begin
      if (m_ctrl[2:1] == 2'b01) begin cleared = 1; ph = 1; end
      else begin c[0] = 1'b0; ph = 0; end
    end
    if (we) begin
      if (a == 2'd0) begin c = d[3:0]; cleared = 1; end
      else if (a == 2'd1) begin p = d; cleared = 1; end
`ifdef TIMER_STATUS_EN
      else if (a == 2'd3 && d[0]) cleared = 1;
`endif
    end
    m_phase = ph; m_ctrl = c; m_preset = p; m_count = cnt;
    if (expired) m_pend = 1;
    else if (cleared) m_pend = 0;
  endtask

  task automatic push_exp(input string nm, input logic [1:0] a);
    exp_t e;
    e.name = nm; e.dout = m_read(a); e.irq = m_irq();
    exp_q.push_back(e);
    -> chk_ev;
  endtask

  task automatic cycle(input logic we, input logic [1:0] a, input logic [31:0] d, input string nm);
    @(negedge clk);
    WE = we; Addr = a; DIn = d;
    #1 push_exp(nm, a);
    @(posedge clk);
    model_step(we, a, d);
  endtask

  // Monitor: compares every expectation the stimulus side publishes.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (DOut === e.dout) n_pass++;
        else $display("FAIL %s DOut actual=%h required=%h at %0t", e.name, DOut, e.dout, $time);
        n_total++;
        if (IRQ === e.irq) n_pass++;
        else $display("FAIL %s IRQ actual=%b required=%b at %0t", e.name, IRQ, e.irq, $time);
      end
    end
  end

  initial begin
    model_reset();
    #12;
    push_exp("rst_ctrl", 2'd0);
    Addr = 2'd1; #1 push_exp("rst_preset", 2'd1);
    Addr = 2'd2; #1 push_exp("rst_count", 2'd2);
    Addr = 2'd3; #1 push_exp("rst_rsvd", 2'd3);
    @(negedge clk); reset = 1'b1;

    // One-shot, IM=1, preset 5
    cycle(1, 2'd1, 32'd5, "os_wr_preset");
    cycle(1, 2'd0, 32'h9, "os_wr_ctrl");
    for (int i = 0; i < 10; i++) cycle(0, 2'd2, 32'd0, "os_count");
    cycle(0, 2'd0, 32'd0, "os_ctrl_after");
    cycle(1, 2'd0, 32'd0, "os_clear");
    cycle(0, 2'd0, 32'd0, "os_cleared");

    // Auto-reload, preset 3
    cycle(1, 2'd1, 32'd3, "rl_wr_preset");
    cycle(1, 2'd0, 32'hB, "rl_wr_ctrl");
    for (int i = 0; i < 16; i++) cycle(0, 2'd2, 32'd0, "rl_count");
    // COUNT is read-only; PRESET change waits for the next reload
    cycle(1, 2'd2, 32'hDEAD, "rl_wr_count");
    cycle(0, 2'd2, 32'd0, "rl_count_kept");
    cycle(1, 2'd1, 32'd9, "rl_wr_preset9");
    for (int i = 0; i < 20; i++) cycle(0, 2'd2, 32'd0, "rl_count9");
    cycle(1, 2'd0, 32'd0, "rl_stop");

    // IM=0 one-shot, preset 2: no IRQ, status bit visible when enabled
    cycle(1, 2'd1, 32'd2, "im0_preset");
    cycle(1, 2'd0, 32'h1, "im0_ctrl");
    for (int i = 0; i < 7; i++) cycle(0, 2'd2, 32'd0, "im0_count");
    cycle(0, 2'd3, 32'd0, "im0_stat");
    cycle(1, 2'd3, 32'd1, "im0_w1c");
    cycle(0, 2'd3, 32'd0, "im0_stat_after");

    // Disable mid-count so COUNT holds at 7
    cycle(1, 2'd1, 32'd20, "dis_preset");
    cycle(1, 2'd0, 32'h9, "dis_ctrl");
    for (int i = 0; i < 40 && m_count != 8; i++) cycle(0, 2'd2, 32'd0, "dis_count");
    cycle(1, 2'd0, 32'h8, "dis_wr_en0");
    for (int i = 0; i < 5; i++) cycle(0, 2'd2, 32'd0, "dis_hold");

    // Zero preset behaves as one
    cycle(1, 2'd1, 32'd0, "z_preset");
    cycle(1, 2'd0, 32'h9, "z_ctrl");
    for (int i = 0; i < 6; i++) cycle(0, 2'd2, 32'd0, "z_count");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1) d = $urandom_range(0, 6);
      if (a == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      cycle(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, a, d, "rand");
    end

    // Asynchronous reset mid-count
    cycle(1, 2'd1, 32'd10, "ar_preset");
    cycle(1, 2'd0, 32'h9, "ar_ctrl");
    for (int i = 0; i < 30 && !(m_phase == 2 && m_count == 5); i++) cycle(0, 2'd2, 32'd0, "ar_count");
    @(negedge clk);
    WE = 1'b0; Addr = 2'd2;
    #2 reset = 1'b0;
    #1 model_reset();
    push_exp("ar_count_now", 2'd2);
    Addr = 2'd0;
    #1 push_exp("ar_ctrl_now", 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 5; i++) cycle(0, 2'd2, 32'd0, "ar_idle");

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
